fifo_wr_ctrl: RTL and testbench

Write-side pointer and status controller of the asynchronous FIFO, running in the write clock domain.
- Owns the binary and Gray write pointers and produces the memory write address and write enable.
- Brings the read domain's Gray read pointer into the write domain through a 2-flop synchronizer, then derives full, almost_full, the fill level and a sticky overflow flag.
- Its registered Gray write pointer is synchronized on the read side and compared there for empty.

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/fifo_wr_ctrl_if.sv | 33 +++
 rtl/fifo_ptr_sync.sv | 33 +++
 rtl/fifo_wr_ctrl.sv | 82 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared pointer helpers for both sides of the asynchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend and truncate.
  localparam int PTR_MAX_W        = 32;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_ADDR_WIDTH   = $clog2(DEF_DEPTH);

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extension keeps the prefix XOR correct for any narrower width.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl_if
// Description : Write-side control/status bundle of the asynchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
) ();

  logic                  W_inc;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   gray_rd_ptr;
  logic [ADDR_WIDTH-1:0] W_addr;
  logic                  W_en;
  logic [ADDR_WIDTH:0]   gray_wr_ptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  modport master (
    output W_inc, ovf_clr, gray_rd_ptr,
    input  W_addr, W_en, gray_wr_ptr, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  W_inc, ovf_clr, gray_rd_ptr,
    output W_addr, W_en, gray_wr_ptr, full, almost_full, wr_level, overflow
  );

endinterface : fifo_wr_ctrl_if
`default_nettype wire

// File: rtl/fifo_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_sync
// Description : Two-flop bus synchronizer for Gray-coded FIFO pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  // Gray coding guarantees at most one bit in flight, so a plain bus sync is safe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule : fifo_ptr_sync
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-domain pointer, full/level and overflow control of the async FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic           W_CLK,
  input  logic           W_RST,
  fifo_wr_ctrl_if.slave  bus
);

  localparam int              ADDR_WIDTH = addr_width(DEPTH);
  localparam int              PW         = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
  localparam logic [PW-1:0]   AF_LEVEL   = PW'(AF_THRESH);

  logic [PW-1:0] r_bn_wr_ptr;
  logic [PW-1:0] r_gray_wr_ptr;
  logic          r_overflow;

  logic [PW-1:0] w_rq2;
  logic [PW-1:0] w_comb_gray;
  logic [PW-1:0] w_full_ref;
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_level;
  logic          w_full;
  logic          w_wr_accept;

  fifo_ptr_sync #(
    .WIDTH (PW)
  ) u_rd_sync (
    .i_clk   (W_CLK),
    .i_rst_n (W_RST),
    .i_d     (bus.gray_rd_ptr),
    .o_q     (w_rq2)
  );

  assign w_comb_gray = PW'(bin2gray(PTR_MAX_W'(r_bn_wr_ptr)));

  // Full when the write side is exactly one lap ahead: top two Gray bits flip.
  assign w_full_ref  = {~w_rq2[PW-1:PW-2], w_rq2[PW-3:0]};
  assign w_full      = (w_comb_gray == w_full_ref);
  assign w_wr_accept = bus.W_inc & ~w_full;

  // Stale read pointer makes this level an upper bound, never an underestimate.
  assign w_rd_bin = PW'(gray2bin(PTR_MAX_W'(w_rq2)));
  assign w_level  = r_bn_wr_ptr - w_rd_bin;

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      r_bn_wr_ptr   <= '0;
      r_gray_wr_ptr <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_bn_wr_ptr <= r_bn_wr_ptr + PTR_ONE;
      end
      r_gray_wr_ptr <= w_comb_gray;
      if (bus.W_inc && w_full) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.W_addr      = r_bn_wr_ptr[ADDR_WIDTH-1:0];
  assign bus.W_en        = w_wr_accept;
  assign bus.gray_wr_ptr = r_gray_wr_ptr;
  assign bus.full        = w_full;
  assign bus.wr_level    = w_level;
  assign bus.almost_full = (w_level >= AF_LEVEL);
  assign bus.overflow    = r_overflow;

endmodule : fifo_wr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ctrl
// Description : Randomized self-checking bench for fifo_wr_ctrl against a count-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AW    = 3;

  logic W_CLK = 1'b0;
  logic W_RST = 1'b0;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF)
  ) u_dut (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .bus   (bus)
  );

  always #5 W_CLK = ~W_CLK;

  int n_chk = 0;
  int n_err = 0;

  // Model: unbounded counts of accepted writes and reads.
  int wr_cnt;
  int prev_wr_cnt;
  int rd_cnt;
  int seen_rd;
  bit m_ovf;
  int rd_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray4(input int c);
    logic [3:0] b;
    b = 4'(c % 16);
    return int'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    wr_cnt      = 0;
    prev_wr_cnt = 0;
    rd_cnt      = 0;
    seen_rd     = 0;
    m_ovf       = 1'b0;
    rd_q.delete();
  endtask

  // One cycle: drive at negedge, check combinational/registered outputs, advance model.
  task automatic step(input bit inc, input bit clr, input int rd);
    int lvl;
    bit f;
    bus.W_inc       = inc;
    bus.ovf_clr     = clr;
    rd_cnt          = rd;
    bus.gray_rd_ptr = 4'(gray4(rd));
    #1;
    lvl = wr_cnt - seen_rd;
    f   = (lvl == DEPTH);
    chk("wr_level",    int'(bus.wr_level),    lvl);
    chk("full",        int'(bus.full),        int'(f));
    chk("almost_full", int'(bus.almost_full), int'(lvl >= AF));
    chk("W_en",        int'(bus.W_en),        int'(inc && !f));
    chk("W_addr",      int'(bus.W_addr),      wr_cnt % DEPTH);
    chk("gray_wr_ptr", int'(bus.gray_wr_ptr), gray4(prev_wr_cnt));
    chk("overflow",    int'(bus.overflow),    int'(m_ovf));
    @(posedge W_CLK);
    prev_wr_cnt = wr_cnt;
    if (inc && !f) wr_cnt++;
    if (inc && f) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    rd_q.push_back(rd);
    if (rd_q.size() > 2) void'(rd_q.pop_front());
    seen_rd = (rd_q.size() == 2) ? rd_q[0] : 0;
    @(negedge W_CLK);
  endtask

  task automatic do_reset();
    @(negedge W_CLK);
    bus.W_inc = 1'b1;
    #2 W_RST = 1'b0;
    #1;
    chk("rst_full",     int'(bus.full),        0);
    chk("rst_af",       int'(bus.almost_full), 0);
    chk("rst_level",    int'(bus.wr_level),    0);
    chk("rst_addr",     int'(bus.W_addr),      0);
    chk("rst_gray",     int'(bus.gray_wr_ptr), 0);
    chk("rst_overflow", int'(bus.overflow),    0);
    bus.W_inc       = 1'b0;
    bus.ovf_clr     = 1'b0;
    bus.gray_rd_ptr = '0;
    model_reset();
    @(negedge W_CLK);
    W_RST = 1'b1;
  endtask

  initial begin
    bus.W_inc       = 1'b0;
    bus.ovf_clr     = 1'b0;
    bus.gray_rd_ptr = '0;
    model_reset();
    repeat (2) @(negedge W_CLK);
    W_RST = 1'b1;

    // Fill with read pointer parked at zero.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0);
    chk("fill_full",  int'(bus.full),     1);
    chk("fill_level", int'(bus.wr_level), DEPTH);

    // Overflow set, plain clear, then clear colliding with a new overflow.
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    chk("ovf_set_wins", int'(bus.overflow), 1);
    step(1'b0, 1'b1, 0);

    // Drain release: one read frees a slot a couple of edges later.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1);

    // Mid-cycle reset while writing, then wrap with reads trailing by three.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, (wr_cnt > 3) ? wr_cnt - 3 : 0);
    step(1'b0, 1'b0, wr_cnt - 3);
    chk("wrap_addr", int'(bus.W_addr), 4);

    // Random concurrent traffic; read rate varies by phase to reach full often.
    for (int ph = 0; ph < 8; ph++) begin
      int rd_pct;
      rd_pct = (ph % 2 == 0) ? 20 : 70;
      for (int c = 0; c < 250; c++) begin
        int nrd;
        nrd = rd_cnt;
        if (rd_cnt < prev_wr_cnt && $urandom_range(99) < rd_pct) nrd = rd_cnt + 1;
        step(($urandom % 4) != 0, ($urandom % 8) == 0, nrd);
      end
    end

    do_reset();
    step(1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
`default_nettype wire
